banked_window_ram: RTL and testbench

BANKED_WINDOW_RAM -- requirements
Module: banked_window_ram

---
 rtl/bwram_pkg.sv | 7 +
 rtl/banked_window_ram_if.sv | 19 +
 rtl/bwram_bank.sv | 18 +
 rtl/banked_window_ram.sv | 92 +++++++++
 tb/tb_banked_window_ram.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/bwram_pkg.sv
// bwram_pkg: read latency and tap/bank rotation helper shared by the banked window RAM
package bwram_pkg;
  localparam int RD_LAT = 2;
  function automatic int bwram_rot(input int i, input int sh, input int taps);
    return (i + sh) & (taps - 1);
  endfunction
endpackage

// File: rtl/banked_window_ram_if.sv
// banked_window_ram_if: write port, window read port and status; master drives, slave (the RAM) responds
interface banked_window_ram_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int TAPS = 4
);
  logic wr_en;
  logic [DATA_W-1:0] wr_data;
  logic rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic rd_valid;
  logic [TAPS*DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0] level;
  logic full;
  logic overflow;
  modport master (output wr_en, wr_data, rd_req, rd_addr, input rd_valid, rd_data, wr_ptr, level, full, overflow);
  modport slave (input wr_en, wr_data, rd_req, rd_addr, output rd_valid, rd_data, wr_ptr, level, full, overflow);
endinterface

// File: rtl/bwram_bank.sv
// bwram_bank: simple dual-port bank, one write port, registered read (read-before-write on collision); ports clock, we/waddr/wdata, raddr/rdata
module bwram_bank #(
  parameter int DATA_W = 16,
  parameter int ROW_W = 6
) (
  input  logic clock,
  input  logic we,
  input  logic [ROW_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ROW_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ROW_W];
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/banked_window_ram.sv
// banked_window_ram: circular write buffer read as TAPS-word windows across TAPS banks; ports clock, reset, bus (banked_window_ram_if.slave); define BWRAM_BYPASS_EN to forward same-cycle writes into the window
module banked_window_ram
  import bwram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int TAPS = 4
) (
  input logic clock,
  input logic reset,
  banked_window_ram_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LT = $clog2(TAPS);
  localparam int ROW_W = ADDR_W - LT;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] level_q, level_d;
  logic overflow_q, overflow_d, full, we;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [LT-1:0] rot_q, rot_d;
  logic [TAPS-1:0] zero_q, zero_d, byp;
  logic [TAPS*DATA_W-1:0] data_q, data_d;
  logic [TAPS-1:0][ADDR_W-1:0] baddr;
  logic [TAPS-1:0][DATA_W-1:0] rdata, bdata;
`ifdef BWRAM_BYPASS_EN
  logic [TAPS-1:0] byp_q;
  logic [DATA_W-1:0] fwd_q;
  always_ff @(posedge clock) begin
    byp_q <= byp;
    fwd_q <= bus.wr_data;
  end
`endif
  always_comb begin
    full = level_q == (ADDR_W+1)'(DEPTH);
    we = bus.wr_en && !reset;
    wr_ptr_d = wr_ptr_q + ADDR_W'(we);
    level_d = level_q + (ADDR_W+1)'(we && !full);
    overflow_d = overflow_q || (we && full);
    vld_d = {vld_q[RD_LAT-2:0], bus.rd_req};
    rot_d = bus.rd_addr[LT-1:0];
    data_d = data_q;
    // bank b serves tap (b - rd_addr) mod TAPS, so every bank is read exactly once per window
    for (int b = 0; b < TAPS; b++) begin
      baddr[b] = bus.rd_addr + ADDR_W'(bwram_rot(b, TAPS - int'(rot_d), TAPS));
`ifdef BWRAM_BYPASS_EN
      byp[b] = we && baddr[b] == wr_ptr_q;
      bdata[b] = byp_q[b] ? fwd_q : rdata[b];
`else
      byp[b] = 1'b0;
      bdata[b] = rdata[b];
`endif
      zero_d[b] = !full && baddr[b] >= wr_ptr_q && !byp[b];
    end
    for (int k = 0; k < TAPS; k++)
      if (vld_q[RD_LAT-2])
        data_d[k*DATA_W +: DATA_W] = zero_q[LT'(bwram_rot(k, int'(rot_q), TAPS))] ? '0 : bdata[LT'(bwram_rot(k, int'(rot_q), TAPS))];
  end
  always_ff @(posedge clock)
    if (reset) begin
      wr_ptr_q <= '0;
      level_q <= '0;
      overflow_q <= 1'b0;
      vld_q <= '0;
      rot_q <= '0;
      zero_q <= '0;
      data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      level_q <= level_d;
      overflow_q <= overflow_d;
      vld_q <= vld_d;
      rot_q <= rot_d;
      zero_q <= zero_d;
      data_q <= data_d;
    end
  for (genvar i = 0; i < TAPS; i++) begin : g_bank
    bwram_bank #(.DATA_W(DATA_W), .ROW_W(ROW_W)) u_bank (
      .clock(clock),
      .we(we && wr_ptr_q[LT-1:0] == LT'(i)),
      .waddr(wr_ptr_q[ADDR_W-1:LT]),
      .wdata(bus.wr_data),
      .raddr(baddr[i][ADDR_W-1:LT]),
      .rdata(rdata[i])
    );
  end
  assign bus.rd_valid = vld_q[RD_LAT-1];
  assign bus.rd_data = data_q;
  assign bus.wr_ptr = wr_ptr_q;
  assign bus.level = level_q;
  assign bus.full = full;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_banked_window_ram.sv
// tb_banked_window_ram: directed self-checking bench for banked_window_ram with default parameters
module tb_banked_window_ram;
  logic clock, reset;
  int tests, fails;
  logic [63:0] bb [4];
  banked_window_ram_if #(.DATA_W(16), .ADDR_W(8), .TAPS(4)) bus ();
  banked_window_ram #(.DATA_W(16), .ADDR_W(8), .TAPS(4)) dut (.clock(clock), .reset(reset), .bus(bus));
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [15:0] v);
    bus.wr_en = 1'b1;
    bus.wr_data = v;
    tick;
    bus.wr_en = 1'b0;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [7:0] a, input logic [63:0] exp);
    bus.rd_req = 1'b1;
    bus.rd_addr = a;
    tick;
    bus.rd_req = 1'b0;
    chk({tag, "_early"}, 64'(bus.rd_valid), 64'd0);
    tick;
    chk({tag, "_valid"}, 64'(bus.rd_valid), 64'd1);
    chk({tag, "_data"}, bus.rd_data, exp);
    tick;
    chk({tag, "_pulse"}, 64'(bus.rd_valid), 64'd0);
    chk({tag, "_hold"}, bus.rd_data, exp);
  endtask
  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_data = 16'hDEAD;
    bus.rd_req = 1'b1;
    bus.rd_addr = '0;
    tick;
    tick;
    reset = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_req = 1'b0;
    chk("rst_wr_ptr", 64'(bus.wr_ptr), 64'd0);
    chk("rst_level", 64'(bus.level), 64'd0);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_rd_data", bus.rd_data, 64'd0);
    tick;
    chk("rst_req_ignored", 64'(bus.rd_valid), 64'd0);
    for (int i = 0; i < 8; i++) wr(16'(i + 1));
    chk("w8_wr_ptr", 64'(bus.wr_ptr), 64'd8);
    chk("w8_level", 64'(bus.level), 64'd8);
    rd("win2", 8'd2, 64'h0006_0005_0004_0003);
    do_reset;
    for (int i = 0; i < 6; i++) wr(16'(i + 1));
    rd("mask4", 8'd4, 64'h0000_0000_0006_0005);
    do_reset;
    for (int i = 0; i < 256; i++) wr(16'(i));
    chk("w256_full", 64'(bus.full), 64'd1);
    chk("w256_level", 64'(bus.level), 64'd256);
    chk("w256_overflow", 64'(bus.overflow), 64'd0);
    chk("w256_wr_ptr", 64'(bus.wr_ptr), 64'd0);
    wr(16'd256);
    wr(16'd257);
    chk("w258_level", 64'(bus.level), 64'd256);
    chk("w258_full", 64'(bus.full), 64'd1);
    chk("w258_overflow", 64'(bus.overflow), 64'd1);
    chk("w258_wr_ptr", 64'(bus.wr_ptr), 64'd2);
    rd("wrap254", 8'd254, 64'h0101_0100_00FF_00FE);
    bb[0] = 64'h0003_0002_0101_0100;
    bb[1] = 64'h0004_0003_0002_0101;
    bb[2] = 64'h0005_0004_0003_0002;
    bb[3] = 64'h0006_0005_0004_0003;
    for (int i = 0; i < 4; i++) begin
      bus.rd_req = 1'b1;
      bus.rd_addr = 8'(i);
      tick;
      if (i == 0) chk("bb_first_early", 64'(bus.rd_valid), 64'd0);
      else begin
        chk($sformatf("bb%0d_valid", i - 1), 64'(bus.rd_valid), 64'd1);
        chk($sformatf("bb%0d_data", i - 1), bus.rd_data, bb[i-1]);
      end
    end
    bus.rd_req = 1'b0;
    tick;
    chk("bb3_valid", 64'(bus.rd_valid), 64'd1);
    chk("bb3_data", bus.rd_data, bb[3]);
    tick;
    chk("bb_end", 64'(bus.rd_valid), 64'd0);
    for (int i = 2; i < 10; i++) wr(16'(i));
    wr(16'hAAAA);
    for (int j = 0; j < 255; j++) wr(16'((11 + j) & 255));
    chk("coll_wr_ptr", 64'(bus.wr_ptr), 64'd10);
    bus.wr_en = 1'b1;
    bus.wr_data = 16'h5555;
    bus.rd_req = 1'b1;
    bus.rd_addr = 8'd10;
    tick;
    bus.wr_en = 1'b0;
    bus.rd_req = 1'b0;
    tick;
    chk("coll_valid", 64'(bus.rd_valid), 64'd1);
`ifdef BWRAM_BYPASS_EN
    chk("coll_data", bus.rd_data, 64'h000D_000C_000B_5555);
`else
    chk("coll_data", bus.rd_data, 64'h000D_000C_000B_AAAA);
`endif
    tick;
    rd("after_coll", 8'd10, 64'h000D_000C_000B_5555);
    bus.rd_req = 1'b1;
    bus.rd_addr = 8'd0;
    tick;
    bus.rd_req = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("cancel_valid", 64'(bus.rd_valid), 64'd0);
    chk("cancel_level", 64'(bus.level), 64'd0);
    chk("cancel_overflow", 64'(bus.overflow), 64'd0);
    chk("cancel_data", bus.rd_data, 64'd0);
    tick;
    chk("cancel_late", 64'(bus.rd_valid), 64'd0);
    rd("stale0", 8'd0, 64'd0);
    rd("stale100", 8'd100, 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
